instr_encoder: RTL
==================

# instr_encoder

Program-load block: accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit RV32I instruction words, and writes them sequentially into the instruction memory write port before the CPU is released. It is the inverse of the immediate-decode path. For every supported format, the 12-bit `imm_i` uses the same bit ordering the CPU's immediate generator produces, so decode(encode(x)) == x. It sits between the testbench/boot loader and the instruction memory.

## Interface
- `ADDR_W`, 32: width of memory address.
- `BASE_ADDR`, 0: byte address of the first written word.
- `DEPTH`, 256: maximum words per load session.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: begin a session; sampled only in IDLE or DONE.
- `in_valid_i` in 1: field set valid.
- `in_ready_o` out 1: block can accept a field set.
- `last_i` in 1: current field set is the final one of the session.
- `opcode_i` in 7: RV32I opcode.
- `rd_i`, `rs1_i`, `rs2_i` in 5 each: register indices.
- `funct3_i` in 3, `funct7_i` in 7: function fields.
- `imm_i` in 12: immediate in decoder ordering.
- `mem_we_o` out 1: write strobe, one cycle per word.
- `mem_addr_o` out ADDR_W: byte address of the word being written.
- `mem_data_o` out 32: encoded instruction.
- `count_o` out $clog2(DEPTH)+1: words written this session.
- `done_o` out 1: session complete.
- `err_o` out 1: sticky; an unsupported opcode was seen this session.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start_i`.
  - LOAD → DONE on an accepted beat with `last_i`=1, or when the accepted beat makes `count`==DEPTH.
  - DONE → LOAD on `start_i`.
  - DONE otherwise holds.
- `in_ready_o` = 1 only in LOAD. A beat is accepted when `in_valid_i & in_ready_o`.
- On `start_i`:
  - Write address ← BASE_ADDR.
  - `count_o` ← 0.
  - `err_o` ← 0.
  - `done_o` ← 0.
- Encoding by opcode:
  - 0010011 / 0000011: {imm[11:0], rs1, funct3, rd, opcode}.
  - 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - 1100011: instr[31]=imm[11], instr[7]=imm[10], instr[30:25]=imm[9:4], instr[11:8]=imm[3:0], plus rs2/rs1/funct3/opcode in their standard positions.
  - 0110011: {funct7, rs2, rs1, funct3, rd, opcode}.
  - Any other opcode: write NOP 32'h00000013, set `err_o`, and still advance the address and count.
- Fields unused by a format are ignored.
- Address increments by 4 per accepted beat. Address wrap at 2^ADDR_W is not checked, because DEPTH bounds the session.
- `start_i` during LOAD is ignored.

## Timing
- Latency: a beat accepted at edge N drives `mem_we_o`=1 with its address and data during cycle N+1 (registered outputs). `mem_we_o` is 0 in every cycle without a write.
- Throughput: one word per cycle while `in_valid_i` stays high.
- `count_o` updates in the same edge as the write registers.
- `done_o` rises in the same cycle the final write is presented.
- No beat is accepted in the cycle LOAD exits: `in_ready_o` is combinational from state and drops the cycle after the final accept.
- Reset values:
  - State IDLE.
  - `in_ready_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `count_o`=0, `done_o`=0, `err_o`=0.
- Reset mid-session: an in-flight write is dropped (`mem_we_o` forced 0 immediately), and the block returns to IDLE.
- `start_i` with a simultaneous `in_valid_i` in IDLE: only the start takes effect. The first accept is possible on the next cycle.

## Structure
- Shared package `rv_isa_pkg` holds the opcode constants (I_ALU, I_LW, S, SB, R) and NOP_INSTR. These constants are reused by the CPU decode path.
- One combinational sub-module, `instr_pack`, maps (fields, imm) to (word, unsupported). The FSM, address/count registers and output registers stay in `instr_encoder`.

## Test plan
- addi x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=0, imm=12'h005) after start → cycle N+1: we=1, addr=0x0, data=0x00500093.
- sw x2,8(x1) (0100011, rs1=1, rs2=2, f3=010, imm=12'h008) as second beat → addr=0x4, data=0x0020A423.
- beq x1,x2 with imm=12'h004 (decoder ordering, branch offset 8) → data=0x00208463. Feeding this word to the immediate decoder returns 12'h004.
- Back-to-back 3 beats with `last_i` on the third → writes at 0x0/0x4/0x8 on consecutive cycles, count=3, done=1, ready=0 afterwards. A fourth valid is not accepted.
- opcode 1111111 → data=0x00000013, err=1 sticky until the next start. Address still advances.
- Reset asserted the cycle after an accept → we=0 immediately, state IDLE, count=0. A subsequent start restarts at BASE_ADDR.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I opcode constants and encoder state type.
// The opcode constants are also consumed by the CPU decode path.
package rv_isa_pkg;

  localparam logic [6:0] I_ALU = 7'b0010011;
  localparam logic [6:0] I_LW  = 7'b0000011;
  localparam logic [6:0] S     = 7'b0100011;
  localparam logic [6:0] SB    = 7'b1100011;
  localparam logic [6:0] R     = 7'b0110011;

  // addi x0,x0,0 -- written in place of any unsupported instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields + decoder-ordered imm -> RV32I word.
// Unknown opcodes yield a NOP and raise unsup_o.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o,
  output logic        unsup_o
);

  // Select the bit layout by format; fields a format does not use are dropped.
  always_comb begin
    word_o  = NOP_INSTR;
    unsup_o = 1'b0;
    case (opcode_i)
      I_ALU, I_LW: word_o = {imm_i, rs1_i, funct3_i, rd_i, opcode_i};
      S:           word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      // imm_i[11:0] here is the decoder's {b12, b11, b10:5, b4:1}
      SB:          word_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                             imm_i[3:0], imm_i[10], opcode_i};
      R:           word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      default: begin
        word_o  = NOP_INSTR;
        unsup_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load block: accepts field sets over valid/ready, packs them into
// RV32I words and writes them sequentially to the instruction memory port.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        DEPTH     = 256,
  localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              last_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [11:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              done_o,
  output logic              err_o
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;       // address of the next word to write
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       word;
  logic              unsup;
  logic              accept, start_ok, final_beat;
  logic [CNT_W-1:0]  count_inc;

  instr_pack u_pack (
    .opcode_i (opcode_i),
    .rd_i     (rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .imm_i    (imm_i),
    .word_o   (word),
    .unsup_o  (unsup)
  );

  // start is only honoured outside LOAD; an accept only happens inside LOAD
  assign accept     = in_valid_i & in_ready_o;
  assign start_ok   = start_i & (state_q != ST_LOAD);
  assign count_inc  = count_q + 1'b1;
  assign final_beat = last_i | (count_inc == CNT_W'(DEPTH));

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i)               state_d = ST_LOAD;
      ST_LOAD: if (accept && final_beat)  state_d = ST_DONE;
      ST_DONE: if (start_i)               state_d = ST_LOAD;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready purely from state so it drops right after the final accept
  always_comb begin
    in_ready_o = (state_q == ST_LOAD);
  end

  // Datapath next-state: session init on start, one write per accepted beat
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    done_d  = done_q;
    err_d   = err_q;
    if (start_ok) begin
      addr_d  = BASE_ADDR;
      count_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept) begin
      we_d    = 1'b1;
      maddr_d = addr_q;
      mdata_d = word;
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_inc;
      err_d   = err_q | unsup;
      done_d  = final_beat;
    end
  end

  // Datapath and output registers; reset drops any in-flight write at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = maddr_q;
  assign mem_data_o = mdata_q;
  assign count_o    = count_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
